i2c_pin_filter: RTL

Input conditioning stage that sits between the SCL/SDA pads and the I2C controller's `cio_scl_i`/`cio_sda_i` inputs.
- Synchronises both open-drain lines into `clk_i` and suppresses spikes shorter than a programmable number of cycles.
- Produces clean levels plus single-cycle edge, START and STOP event strobes for the controller and for debug/interrupt logic.

---
 rtl/i2c_pin_filter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/i2c_pin_filter.sv
// Synchronises raw SCL/SDA pad inputs, rejects spikes of up to filt_cycles_i sampled cycles,
// and emits registered edge, START/STOP and glitch-rejected strobes alongside the clean levels.
module i2c_pin_filter #(
   parameter int SyncStages = 2,
   parameter int FiltW      = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             enable_i,
   input  logic [FiltW-1:0] filt_cycles_i,
   input  logic             scl_pad_i,
   input  logic             sda_pad_i,
   output logic             scl_o,
   output logic             sda_o,
   output logic             scl_rise_o,
   output logic             scl_fall_o,
   output logic             sda_rise_o,
   output logic             sda_fall_o,
   output logic             start_det_o,
   output logic             stop_det_o,
   output logic             scl_glitch_o,
   output logic             sda_glitch_o
);

   localparam logic [FiltW-1:0] CntOne = FiltW'(1);

   // Index 0 carries SCL, index 1 carries SDA throughout.
   logic [SyncStages-1:0] r_sync [2];
   logic [FiltW-1:0]      r_cnt  [2];
   logic [1:0]            r_stable;
   logic [1:0]            r_rise;
   logic [1:0]            r_fall;
   logic [1:0]            r_glitch;
   logic                  r_start;
   logic                  r_stop;

   logic [1:0]            w_pad;
   logic [1:0]            w_sync;
   logic [1:0]            w_diff;
   logic [1:0]            w_upd;
   logic [1:0]            w_glitch;
   logic                  w_start;
   logic                  w_stop;

   assign w_pad = {sda_pad_i, scl_pad_i};

   for (genvar g = 0; g < 2; g++) begin : g_line
      assign w_sync[g]   = r_sync[g][SyncStages-1];
      assign w_diff[g]   = w_sync[g] != r_stable[g];
      // >= rather than == so a threshold lowered mid-count releases at once.
      assign w_upd[g]    = w_diff[g] && (r_cnt[g] >= filt_cycles_i);
      assign w_glitch[g] = !w_diff[g] && (r_cnt[g] != '0);
   end

   // SCL must be holding high and not itself moving for SDA to qualify as START/STOP.
   assign w_start = w_upd[1] && !w_sync[1] && r_stable[0] && !w_upd[0];
   assign w_stop  = w_upd[1] &&  w_sync[1] && r_stable[0] && !w_upd[0];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int g = 0; g < 2; g++) begin
            r_sync[g] <= '1;
         end
      end else begin
         for (int g = 0; g < 2; g++) begin
            r_sync[g] <= {r_sync[g][SyncStages-2:0], w_pad[g]};
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stable <= 2'b11;
         r_rise   <= 2'b00;
         r_fall   <= 2'b00;
         r_glitch <= 2'b00;
         r_start  <= 1'b0;
         r_stop   <= 1'b0;
         for (int g = 0; g < 2; g++) begin
            r_cnt[g] <= '0;
         end
      end else if (!enable_i) begin
         r_stable <= 2'b11;
         r_rise   <= 2'b00;
         r_fall   <= 2'b00;
         r_glitch <= 2'b00;
         r_start  <= 1'b0;
         r_stop   <= 1'b0;
         for (int g = 0; g < 2; g++) begin
            r_cnt[g] <= '0;
         end
      end else begin
         r_rise   <= w_upd &  w_sync;
         r_fall   <= w_upd & ~w_sync;
         r_glitch <= w_glitch;
         r_start  <= w_start;
         r_stop   <= w_stop;
         for (int g = 0; g < 2; g++) begin
            if (w_upd[g]) begin
               r_stable[g] <= w_sync[g];
               r_cnt[g]    <= '0;
            end else if (w_diff[g]) begin
               r_cnt[g]    <= r_cnt[g] + CntOne;
            end else begin
               r_cnt[g]    <= '0;
            end
         end
      end
   end

   assign scl_o        = r_stable[0];
   assign sda_o        = r_stable[1];
   assign scl_rise_o   = r_rise[0];
   assign scl_fall_o   = r_fall[0];
   assign sda_rise_o   = r_rise[1];
   assign sda_fall_o   = r_fall[1];
   assign start_det_o  = r_start;
   assign stop_det_o   = r_stop;
   assign scl_glitch_o = r_glitch[0];
   assign sda_glitch_o = r_glitch[1];

endmodule
